// File: rtl/apb_initiator_pkg.sv
// Shared types for the APB requester: FSM state encoding and response codes.
package apb_initiator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_t;

  typedef enum logic [1:0] {
    RSP_OK      = 2'd0,
    RSP_SLVERR  = 2'd1,
    RSP_TIMEOUT = 2'd2
  } rsp_code_t;

  function automatic logic rsp_is_err(rsp_code_t code);
    return code != RSP_OK;
  endfunction

endpackage

// File: rtl/apb_initiator.sv
// APB3 requester: one outstanding transfer from a valid/ready command port,
// registered APB outputs, bounded ACCESS wait states with timeout abort.
module apb_initiator
  import apb_initiator_pkg::*;
#(
  parameter int unsigned W_ADDR         = 16,
  parameter int unsigned W_DATA         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [W_ADDR-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [W_DATA-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W_DATA-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [W_ADDR-1:0] apbm_paddr,
  output logic              apbm_psel,
  output logic              apbm_penable,
  output logic              apbm_pwrite,
  output logic [W_DATA-1:0] apbm_pwdata,
  input  logic              apbm_pready,
  input  logic [W_DATA-1:0] apbm_prdata,
  input  logic              apbm_pslverr
);

  localparam int unsigned W_CNT = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [W_CNT-1:0] CNT_LAST =
    W_CNT'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  apb_state_t       state;
  rsp_code_t        rsp_code;
  logic [W_CNT-1:0] acc_cnt;
  logic             accept;

  // In RESP the command port opens in the same cycle the response is consumed.
  assign cmd_ready   = !rst && ((state == ST_IDLE) || (state == ST_RESP && rsp_ready));
  assign accept      = cmd_valid && cmd_ready;
  assign rsp_err     = rsp_is_err(rsp_code);
  assign rsp_timeout = (rsp_code == RSP_TIMEOUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      rsp_code     <= RSP_OK;
      acc_cnt      <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      apbm_paddr   <= '0;
      apbm_psel    <= 1'b0;
      apbm_penable <= 1'b0;
      apbm_pwrite  <= 1'b0;
      apbm_pwdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            apbm_paddr  <= cmd_addr;
            apbm_pwrite <= cmd_write;
            apbm_pwdata <= cmd_wdata;
            apbm_psel   <= 1'b1;
            state       <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          apbm_penable <= 1'b1;
          acc_cnt      <= '0;
          state        <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (apbm_pready) begin
            apbm_psel    <= 1'b0;
            apbm_penable <= 1'b0;
            rsp_rdata    <= apbm_pwrite ? '0 : apbm_prdata;
            rsp_code     <= apbm_pslverr ? RSP_SLVERR : RSP_OK;
            rsp_valid    <= 1'b1;
            state        <= ST_RESP;
          end else if (TIMEOUT_EN && acc_cnt == CNT_LAST) begin
            // acc_cnt lags the ACCESS cycle number by one, so this is cycle TIMEOUT_CYCLES.
            apbm_psel    <= 1'b0;
            apbm_penable <= 1'b0;
            rsp_rdata    <= '0;
            rsp_code     <= RSP_TIMEOUT;
            rsp_valid    <= 1'b1;
            state        <= ST_RESP;
          end else if (TIMEOUT_EN) begin
            acc_cnt <= acc_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (cmd_valid) begin
              apbm_paddr  <= cmd_addr;
              apbm_pwrite <= cmd_write;
              apbm_pwdata <= cmd_wdata;
              apbm_psel   <= 1'b1;
              state       <= ST_SETUP;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
